uart_boot_ctrl: RTL
===================

# uart_boot_ctrl

Boot-load controller between the UART byte receiver and instruction/data memory. On a start request it holds the CPU in reset, packs received bytes little-endian into 32-bit words, and writes them to sequential memory addresses through a valid/ack port. It ends the load on an idle timeout or a word limit, flushes any partial word, then releases the CPU.

## Interface
- `DATA_W`, 32: memory word width; fixed at 4 bytes.
- `ADDR_W`, 32: memory byte-address width.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first word.
- `MAX_WORDS`, 16384: word limit that ends the load.
- `IDLE_CYCLES`, 65535: clk cycles with no byte, after the first byte, that end the load.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle boot request.
- `rx_byte` input 8: received byte.
- `rx_valid` input 1: one-cycle strobe qualifying `rx_byte`.
- `mem_we` output 1: write request, held until acknowledged.
- `mem_addr` output ADDR_W: byte address of the write.
- `mem_wdata` output DATA_W: write data.
- `mem_ack` input 1: write accepted in a cycle where `mem_we` = 1.
- `cpu_hold` output 1: holds the CPU in reset while asserted.
- `busy` output 1: load in progress.
- `done` output 1: load finished (level).
- `err` output 1: sticky overrun flag.

## Operation
- States (`boot_state_t`):
  - IDLE: after reset.
  - RECV: loading.
  - FLUSH: writing the final partial word, or waiting for the last pending write.
  - DONE: load finished.
- IDLE:
  - `start` -> RECV.
  - `rx_valid` is ignored.
- RECV, byte handling:
  - Each `rx_valid` stores `rx_byte` into lane `byte_cnt` (lane 0 = bits 7:0), increments `byte_cnt` (2 bits, wraps 3->0) and clears the idle counter.
  - On the 4th byte the word moves to the write register: `mem_we` = 1, `mem_addr` = BASE_ADDR + 4*`word_idx`.
  - `word_idx` increments when `mem_we` and `mem_ack` are both high.
- RECV, exits:
  - Idle counter starts only after the first byte of the load. When it reaches IDLE_CYCLES -> FLUSH.
  - When `word_idx` reaches MAX_WORDS -> DONE. Later bytes are ignored.
- FLUSH:
  - If `byte_cnt` != 0, write the partial word with unfilled lanes zero.
  - When no write is pending -> DONE.
- DONE:
  - `done` = 1 and `cpu_hold` = 0.
  - `start` restarts the load: -> RECV, clears `word_idx`, `byte_cnt`, `err` and the idle counter.
- Overrun: if a word completes while the previous write is still unacknowledged, the new word is dropped, `err` is set, and `word_idx` is unchanged.
- Simultaneous events:
  - `rx_valid` with idle-counter expiry: the byte wins and the counter clears.
  - `start` in RECV or FLUSH is ignored.
  - `mem_ack` without `mem_we` is ignored.
- `cpu_hold` = 1 in RECV and FLUSH, 0 in IDLE and DONE.
- `busy` = 1 in RECV and FLUSH.

## Timing
- Reset values:
  - state IDLE.
  - `mem_we`, `cpu_hold`, `busy`, `done`, `err` = 0.
  - `mem_addr` = BASE_ADDR, `mem_wdata` = 0.
  - all counters 0.
- `start` at cycle t: `cpu_hold` and `busy` = 1 at t+1.
- 4th `rx_valid` at t: `mem_we` with valid address and data at t+1.
- `mem_ack` may be high in the same cycle `mem_we` rises; `mem_we` falls the cycle after the ack.
- Address and data stay stable while `mem_we` = 1.
- Last byte at t, no further bytes: FLUSH at t+IDLE_CYCLES+1; DONE one cycle after the last ack.
- `done` and the release of `cpu_hold` occur in the same cycle.
- Reset during a load aborts it immediately: pending write dropped, `mem_we` = 0.
- Widths:
  - `word_idx` is $clog2(MAX_WORDS)+1 bits; no wrap.
  - Idle counter is $clog2(IDLE_CYCLES+1) bits and saturates.

## Structure
- Shared package `boot_pkg`: `boot_state_t` (IDLE, RECV, FLUSH, DONE) plus default constants for MAX_WORDS and IDLE_CYCLES, alongside the existing baud constants.
- One sub-module, `boot_word_packer`: byte lanes, `byte_cnt`, word-complete strobe, zero-padded flush output.
- The FSM, idle timer and write register stay in the top module.

## Test plan
- Reset, then `start`, then bytes 78 56 34 12 with `mem_ack` tied high -> one write, addr 0x0, data 0x12345678. After IDLE_CYCLES -> `done` = 1, `cpu_hold` = 0.
- 6 bytes 01..06 -> write 0x04030201 at 0x0, then after timeout FLUSH writes 0x00000605 at 0x4, then DONE.
- MAX_WORDS = 4, 20 bytes sent -> exactly 4 writes (0x0..0xC), DONE after the 4th ack, remaining bytes produce no write.
- `mem_ack` withheld for 10 cycles while 4 more bytes complete a word -> `err` = 1, first write retained then acked, second word dropped, next address still 0x4.
- `rst` low mid-word and mid-write -> all outputs at reset values within the same cycle, no further writes.
- `start` in DONE -> RECV, `err` and `done` cleared, next write addressed at BASE_ADDR.

Source files
------------

// File: rtl/boot_pkg.sv
// boot_pkg: shared types and defaults for the boot loader
// and its UART front-end.
package boot_pkg;

  localparam int unsigned CLK_HZ    = 50_000_000;
  localparam int unsigned BAUD_RATE = 115_200;
  localparam int unsigned BAUD_DIV  = CLK_HZ / BAUD_RATE;

  localparam int unsigned BOOT_MAX_WORDS   = 16384;
  localparam int unsigned BOOT_IDLE_CYCLES = 65535;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    FLUSH,
    DONE
  } boot_state_t;

endpackage

// File: rtl/boot_word_packer.sv
// boot_word_packer: little-endian byte-to-word assembler.
// Lanes clear on each full word so a flush is zero-padded.
module boot_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [1:0]  byte_cnt,
  output logic [31:0] word_full,
  output logic [31:0] pad_word
);

  logic [3:0][7:0] lanes_q;
  logic [1:0]      cnt_q;

  // Store each accepted byte in its lane; restart lanes after lane 3.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lanes_q <= '0;
      cnt_q   <= '0;
    end else if (clr) begin
      lanes_q <= '0;
      cnt_q   <= '0;
    end else if (en && byte_valid) begin
      if (cnt_q == 2'd3) begin
        lanes_q <= '0;
      end else begin
        lanes_q[cnt_q] <= byte_in;
      end
      cnt_q <= cnt_q + 2'd1;
    end
  end

  assign byte_cnt  = cnt_q;
  assign word_full = {byte_in, lanes_q[2], lanes_q[1], lanes_q[0]};
  assign pad_word  = lanes_q;

endmodule

// File: rtl/uart_boot_ctrl.sv
// uart_boot_ctrl: holds the CPU in reset while UART bytes
// are packed into words and written to memory.
module uart_boot_ctrl #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       MAX_WORDS   = boot_pkg::BOOT_MAX_WORDS,
  parameter int unsigned       IDLE_CYCLES = boot_pkg::BOOT_IDLE_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import boot_pkg::*;

  localparam int WI_W = $clog2(MAX_WORDS) + 1;
  localparam int IC_W = $clog2(IDLE_CYCLES + 1);

  localparam logic [WI_W-1:0] WI_LAST = WI_W'(MAX_WORDS - 1);
  localparam logic [IC_W-1:0] IC_MAX  = IC_W'(IDLE_CYCLES);
  localparam logic [IC_W-1:0] IC_LAST = IC_W'(IDLE_CYCLES - 1);

  boot_state_t     state_q;
  boot_state_t     state_d;
  logic [WI_W-1:0] word_idx_q;
  logic [WI_W-1:0] widx_nxt;
  logic [IC_W-1:0] idle_q;
  logic            seen_q;

  logic        restart;
  logic        pk_clr;
  logic        load_full;
  logic        load_pad;
  logic        set_err;
  logic        idle_clr;
  logic        idle_inc;

  logic        ack_fire;
  logic        wr_busy;
  logic        hit_max;
  logic        pk_en;
  logic        byte_take;
  logic        word_done;
  logic [1:0]  byte_cnt;
  logic [31:0] word_full;
  logic [31:0] pad_word;
  logic [ADDR_W-1:0] wr_addr;

  // An ack completes the pending write; a word that arrives
  // while the write is still unacked cannot be queued.
  assign ack_fire  = mem_we & mem_ack;
  assign wr_busy   = mem_we & ~mem_ack;
  assign hit_max   = ack_fire && (word_idx_q == WI_LAST);
  assign pk_en     = (state_q == RECV) && !hit_max;
  assign byte_take = pk_en & rx_valid;
  assign word_done = byte_take && (byte_cnt == 2'd3);
  assign widx_nxt  = word_idx_q + WI_W'(ack_fire);
  assign wr_addr   = BASE_ADDR + (ADDR_W'(widx_nxt) << 2);

  boot_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (pk_clr | restart),
    .en         (pk_en),
    .byte_valid (rx_valid),
    .byte_in    (rx_byte),
    .byte_cnt   (byte_cnt),
    .word_full  (word_full),
    .pad_word   (pad_word)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_d   = state_q;
    restart   = 1'b0;
    pk_clr    = 1'b0;
    load_full = 1'b0;
    load_pad  = 1'b0;
    set_err   = 1'b0;
    idle_clr  = 1'b0;
    idle_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RECV;
          restart = 1'b1;
        end
      end
      RECV: begin
        if (hit_max) begin
          state_d = DONE;
        end else begin
          if (word_done) begin
            if (wr_busy) begin
              set_err = 1'b1;
            end else begin
              load_full = 1'b1;
            end
          end
          if (byte_take) begin
            idle_clr = 1'b1;
          end else if (seen_q) begin
            idle_inc = 1'b1;
            if (idle_q >= IC_LAST) begin
              state_d = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (hit_max) begin
          state_d = DONE;
        end else if (!wr_busy) begin
          if (byte_cnt != 2'd0) begin
            load_pad = 1'b1;
            pk_clr   = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d = RECV;
          restart = 1'b1;
        end
      end
    endcase
  end

  // Idle timer: armed by the first byte, cleared by every byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_q <= '0;
      seen_q <= 1'b0;
    end else if (restart) begin
      idle_q <= '0;
      seen_q <= 1'b0;
    end else if (idle_clr) begin
      idle_q <= '0;
      seen_q <= 1'b1;
    end else if (idle_inc && idle_q != IC_MAX) begin
      idle_q <= idle_q + IC_W'(1);
    end
  end

  // Write register, word index and sticky overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= '0;
      word_idx_q <= '0;
      err        <= 1'b0;
    end else if (restart) begin
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= '0;
      word_idx_q <= '0;
      err        <= 1'b0;
    end else begin
      if (ack_fire) begin
        mem_we     <= 1'b0;
        word_idx_q <= widx_nxt;
      end
      if (load_full || load_pad) begin
        mem_we    <= 1'b1;
        mem_addr  <= wr_addr;
        mem_wdata <= load_full ? word_full : pad_word;
      end
      if (set_err) begin
        err <= 1'b1;
      end
    end
  end

  assign busy     = (state_q == RECV) || (state_q == FLUSH);
  assign cpu_hold = busy;
  assign done     = (state_q == DONE);

endmodule
